// File: rtl/or1200_keccak_ctrl.sv
// Keccak custom-instruction sequencer: packs CPU words into 64-bit core beats with padding
// requests, throttles on core back-pressure, and serves the captured digest word by word.
module or1200_keccak_ctrl #(
   parameter int OUT_WORDS = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   input  logic [2:0]             cmd_op,
   input  logic [31:0]            cmd_data,
   input  logic [2:0]             cmd_bytes,
   input  logic [3:0]             cmd_idx,
   output logic                   cmd_stall,
   output logic [31:0]            rd_data,
   output logic                   busy,
   output logic                   done,
   output logic                   core_reset,
   output logic [63:0]            core_in,
   output logic [2:0]             core_byte_num,
   output logic                   core_in_ready,
   output logic                   core_is_last,
   input  logic                   core_buffer_full,
   input  logic [OUT_WORDS*32-1:0] core_out,
   input  logic                   core_out_ready
);

   localparam logic [2:0] OP_INIT       = 3'd0;
   localparam logic [2:0] OP_WRITE      = 3'd1;
   localparam logic [2:0] OP_WRITE_LAST = 3'd2;
   localparam logic [2:0] OP_READ       = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LO    = 3'd1,
      ST_HI    = 3'd2,
      ST_FLUSH = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            hold_q, hold_d;
   logic [OUT_WORDS*32-1:0] digest_q, digest_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic [31:0]            rd_data_q, rd_data_d;
   logic                   core_reset_q, core_reset_d;
   logic [63:0]            core_in_q, core_in_d;
   logic [2:0]             byte_num_q, byte_num_d;
   logic                   in_ready_q, in_ready_d;
   logic                   is_last_q, is_last_d;

   logic                   stall_s;
   logic                   accept_s;
   logic                   is_init_s, is_wr_s, is_wl_s, is_rd_s;
   logic [2:0]             bytes_s;
   logic [31:0]            read_word_s;

   // Back-pressure: writes wait for the core, and nothing but INIT/NOP passes while a digest is owed
   always_comb begin
      stall_s = 1'b0;
      case (cmd_op)
         OP_WRITE, OP_WRITE_LAST: begin
            case (state_q)
               ST_LO, ST_HI:     stall_s = core_buffer_full | in_ready_q;
               ST_FLUSH, ST_WAIT: stall_s = 1'b1;
               default:          stall_s = 1'b0;
            endcase
         end
         OP_READ: stall_s = (state_q == ST_FLUSH) || (state_q == ST_WAIT);
         default: stall_s = 1'b0;
      endcase
   end

   assign accept_s  = cmd_valid & ~stall_s;
   assign is_init_s = accept_s && (cmd_op == OP_INIT);
   assign is_wr_s   = accept_s && (cmd_op == OP_WRITE);
   assign is_wl_s   = accept_s && (cmd_op == OP_WRITE_LAST);
   assign is_rd_s   = accept_s && (cmd_op == OP_READ);
   assign bytes_s   = (cmd_bytes > 3'd4) ? 3'd4 : cmd_bytes;

   // Digest word select; word 0 is the most significant slice
   always_comb begin
      read_word_s = 32'h0;
      for (int w = 0; w < OUT_WORDS; w++) begin
         if (int'(cmd_idx) == w) begin
            read_word_s = digest_q[(OUT_WORDS-1-w)*32 +: 32];
         end else begin
            read_word_s = read_word_s;
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      digest_d     = digest_q;
      done_d       = done_q;
      busy_d       = busy_q;
      rd_data_d    = rd_data_q;
      core_reset_d = 1'b0;
      core_in_d    = 64'h0;
      byte_num_d   = 3'd0;
      in_ready_d   = 1'b0;
      is_last_d    = 1'b0;
      if (is_init_s) begin
         core_reset_d = 1'b1;
         hold_d       = 32'h0;
         digest_d     = '0;
         done_d       = 1'b0;
         busy_d       = 1'b1;
         rd_data_d    = 32'h0;
         state_d      = ST_LO;
      end else begin
         case (state_q)
            ST_LO: begin
               if (is_wr_s) begin
                  hold_d  = cmd_data;
                  state_d = ST_HI;
               end else if (is_wl_s) begin
                  core_in_d  = {cmd_data, 32'h0};
                  byte_num_d = bytes_s;
                  in_ready_d = 1'b1;
                  is_last_d  = 1'b1;
                  state_d    = ST_WAIT;
               end else if (is_rd_s) begin
                  rd_data_d = 32'h0;
               end else begin
                  state_d = ST_LO;
               end
            end
            ST_HI: begin
               if (is_wr_s) begin
                  core_in_d  = {hold_q, cmd_data};
                  in_ready_d = 1'b1;
                  state_d    = ST_LO;
               end else if (is_wl_s) begin
                  core_in_d  = {hold_q, cmd_data};
                  in_ready_d = 1'b1;
                  // A full final beat leaves the padding for an empty trailing beat
                  if (bytes_s == 3'd4) begin
                     state_d = ST_FLUSH;
                  end else begin
                     byte_num_d = 3'd4 + bytes_s;
                     is_last_d  = 1'b1;
                     state_d    = ST_WAIT;
                  end
               end else if (is_rd_s) begin
                  rd_data_d = 32'h0;
               end else begin
                  state_d = ST_HI;
               end
            end
            ST_FLUSH: begin
               if (!core_buffer_full && !in_ready_q) begin
                  in_ready_d = 1'b1;
                  is_last_d  = 1'b1;
                  state_d    = ST_WAIT;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            ST_WAIT: begin
               if (core_out_ready) begin
                  digest_d = core_out;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_DONE: begin
               if (is_rd_s) begin
                  rd_data_d = read_word_s;
               end else begin
                  rd_data_d = rd_data_q;
               end
            end
            ST_IDLE: begin
               if (is_rd_s) begin
                  rd_data_d = 32'h0;
               end else begin
                  rd_data_d = rd_data_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         hold_q       <= 32'h0;
         digest_q     <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         rd_data_q    <= 32'h0;
         core_reset_q <= 1'b0;
         core_in_q    <= 64'h0;
         byte_num_q   <= 3'd0;
         in_ready_q   <= 1'b0;
         is_last_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         digest_q     <= digest_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         rd_data_q    <= rd_data_d;
         core_reset_q <= core_reset_d;
         core_in_q    <= core_in_d;
         byte_num_q   <= byte_num_d;
         in_ready_q   <= in_ready_d;
         is_last_q    <= is_last_d;
      end
   end

   assign cmd_stall     = stall_s;
   assign rd_data       = rd_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign core_reset    = core_reset_q;
   assign core_in       = core_in_q;
   assign core_byte_num = byte_num_q;
   assign core_in_ready = in_ready_q;
   assign core_is_last  = is_last_q;

endmodule
